// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the hex scan display.
//   - segment bit indices (bit0 = a ... bit6 = g)
//   - HEX_SEG: 16-entry hex -> segment table (active-high, 1 = lit)
//   - scan_state_t: OFF / SHOW / GUARD sequencing states
package seg7_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Entry n is the glyph for nibble n; b and d are lowercase.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,  // F E d C b A 9 8
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F   // 7 6 5 4 3 2 1 0
  };

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_SHOW  = 2'd1,
    ST_GUARD = 2'd2
  } scan_state_t;

endpackage

// File: rtl/hex_scan_timer.sv
// hex_scan_timer: digit scan sequencer.
//   Walks OFF -> SHOW(idx) -> GUARD -> SHOW(idx+1) ... with SLOT_CYC lit
//   clocks and GUARD_CYC dark clocks per digit. frame_wrap is a one-cycle
//   combinational pulse on the cycle whose edge moves the scan to digit 0
//   (OFF->SHOW entry, or wrap after the last digit); the owner commits new
//   display data on that edge.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   en              scan enable; low forces OFF
//   state           current sequencing state
//   idx             current digit index
//   frame_wrap      next edge starts a frame at digit 0
module hex_scan_timer
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SLOT_CYC   = 50000,
  parameter int GUARD_CYC  = 16,
  parameter int IW         = $clog2(NUM_DIGITS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output scan_state_t   state,
  output logic [IW-1:0] idx,
  output logic          frame_wrap
);

  localparam int MAXC = (SLOT_CYC > GUARD_CYC) ? SLOT_CYC : GUARD_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  scan_state_t   state_n;
  logic [IW-1:0] idx_n;
  logic [CW-1:0] slot_cnt, slot_cnt_n;
  logic          last;

  assign last = (idx == IW'(NUM_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_OFF;
      idx      <= '0;
      slot_cnt <= '0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      slot_cnt <= slot_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    slot_cnt_n = slot_cnt;
    frame_wrap = 1'b0;
    case (state)
      ST_OFF: begin
        if (en) begin
          state_n    = ST_SHOW;
          idx_n      = '0;
          slot_cnt_n = '0;
          frame_wrap = 1'b1;
        end
      end
      ST_SHOW: begin
        if (!en) begin
          state_n    = ST_OFF;
          idx_n      = '0;
          slot_cnt_n = '0;
        end else if (slot_cnt == CW'(SLOT_CYC - 1)) begin
          slot_cnt_n = '0;
          if (GUARD_CYC == 0) begin
            // no dark gap: step straight to the next digit
            idx_n      = last ? '0 : idx + IW'(1);
            frame_wrap = last;
          end else begin
            state_n = ST_GUARD;
          end
        end else begin
          slot_cnt_n = slot_cnt + CW'(1);
        end
      end
      ST_GUARD: begin
        if (!en) begin
          state_n    = ST_OFF;
          idx_n      = '0;
          slot_cnt_n = '0;
        end else if (slot_cnt == CW'(GUARD_CYC - 1)) begin
          state_n    = ST_SHOW;
          slot_cnt_n = '0;
          idx_n      = last ? '0 : idx + IW'(1);
          frame_wrap = last;
        end else begin
          slot_cnt_n = slot_cnt + CW'(1);
        end
      end
      default: begin
        state_n    = ST_OFF;
        idx_n      = '0;
        slot_cnt_n = '0;
      end
    endcase
  end

endmodule

// File: rtl/hex_scan_display.sv
// hex_scan_display: time-multiplexed 7-segment digit controller.
//   load captures value/dp_mask into a staging buffer; staging is copied to
//   the active buffer only when the scan starts a frame at digit 0, so a
//   frame never mixes old and new data. All pins are registered; en is also
//   applied directly to the output registers so the display goes dark on the
//   edge that samples en low.
//   Optional: define HEX_SCAN_LZB_EN for leading-zero blanking (digits above
//   the highest nonzero nibble show no segments; digit 0 never blanks).
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   en            scan enable
//   load          strobe: capture value/dp_mask
//   value         nibble k drives digit k (digit 0 rightmost)
//   dp_mask       decimal point per digit
//   upd_pending   staging holds data not yet shown
//   seg           segments a..g on bits 0..6
//   dp            decimal point of the lit digit
//   dig_en        one-hot digit select, zero when dark
//   (INVERT=1 complements seg, dp, dig_en at the pins)
module hex_scan_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SLOT_CYC   = 50000,
  parameter int GUARD_CYC  = 16,
  parameter bit INVERT     = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic                    upd_pending,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   dig_en
);

  localparam int IW = $clog2(NUM_DIGITS);

  scan_state_t                 state;
  logic [IW-1:0]               idx;
  logic                        frame_wrap;
  logic                        commit;
  logic                        lit;

  logic [NUM_DIGITS-1:0][3:0]  stg_val, act_val;
  logic [NUM_DIGITS-1:0]       stg_dp, act_dp;
  logic [NUM_DIGITS-1:0]       blank;

  logic [6:0]                  seg_r, seg_n;
  logic                        dp_r, dp_n;
  logic [NUM_DIGITS-1:0]       dig_r, dig_n;

  hex_scan_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .SLOT_CYC   (SLOT_CYC),
    .GUARD_CYC  (GUARD_CYC),
    .IW         (IW)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .state      (state),
    .idx        (idx),
    .frame_wrap (frame_wrap)
  );

  assign commit = frame_wrap & upd_pending;
  assign lit    = (state == ST_SHOW) & en;

  // Per-digit blank flags: digit k is blank when it and every digit above
  // it are zero.
  genvar k;
  generate
    for (k = 0; k < NUM_DIGITS; k++) begin : g_blank
`ifdef HEX_SCAN_LZB_EN
      if (k == 0) begin : g_d0
        assign blank[k] = 1'b0;
      end else begin : g_dk
        assign blank[k] = ~|act_val[NUM_DIGITS-1:k];
      end
`else
      assign blank[k] = 1'b0;
`endif
    end
  endgenerate

  always_comb begin
    seg_n = '0;
    dp_n  = 1'b0;
    dig_n = '0;
    if (lit) begin
      dig_n[idx] = 1'b1;
      seg_n[SEG_G:SEG_A] = blank[idx] ? 7'h00 : HEX_SEG[act_val[idx]];
      dp_n       = act_dp[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stg_val     <= '0;
      stg_dp      <= '0;
      act_val     <= '0;
      act_dp      <= '0;
      upd_pending <= 1'b0;
      seg_r       <= '0;
      dp_r        <= 1'b0;
      dig_r       <= '0;
    end else begin
      seg_r <= seg_n;
      dp_r  <= dp_n;
      dig_r <= dig_n;
      // commit reads the pre-edge staging, so a same-cycle load lands
      // in staging for the following frame and keeps upd_pending set
      if (commit) begin
        act_val <= stg_val;
        act_dp  <= stg_dp;
      end
      if (load) begin
        stg_val     <= value;
        stg_dp      <= dp_mask;
        upd_pending <= 1'b1;
      end else if (commit) begin
        upd_pending <= 1'b0;
      end
    end
  end

  assign seg    = seg_r ^ {7{INVERT}};
  assign dp     = dp_r ^ INVERT;
  assign dig_en = dig_r ^ {NUM_DIGITS{INVERT}};

endmodule

// File: tb/tb_hex_scan_display.sv
// Bench for hex_scan_display: NUM_DIGITS=4, SLOT_CYC=4, GUARD_CYC=2.
// A second instance with INVERT=1 shares all inputs; its pins must be the
// complement of the first. Stimulus pushes the expected lit-digit sequence
// into a queue; a negedge monitor pops one entry each time a new digit lights.
module tb_hex_scan_display;

  localparam int ND = 4;

  logic          clk = 1'b0;
  logic          rst, en, load;
  logic [15:0]   value;
  logic [ND-1:0] dp_mask;
  logic          upd_pending, dp, inv_upd, inv_dp;
  logic [6:0]    seg, inv_seg;
  logic [ND-1:0] dig_en, inv_dig;

  always #5 clk = ~clk;

  hex_scan_display #(.NUM_DIGITS(ND), .SLOT_CYC(4), .GUARD_CYC(2), .INVERT(1'b0)) u_dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .value(value), .dp_mask(dp_mask),
    .upd_pending(upd_pending), .seg(seg), .dp(dp), .dig_en(dig_en));

  hex_scan_display #(.NUM_DIGITS(ND), .SLOT_CYC(4), .GUARD_CYC(2), .INVERT(1'b1)) u_inv (
    .clk(clk), .rst(rst), .en(en), .load(load), .value(value), .dp_mask(dp_mask),
    .upd_pending(inv_upd), .seg(inv_seg), .dp(inv_dp), .dig_en(inv_dig));

  typedef struct packed {
    logic [ND-1:0] dig;
    logic [6:0]    seg;
    logic          dp;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [11:0] mon_inv_req;
  logic [ND-1:0] prev_dig = '0;
  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int t0     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // advance to 1 time unit after edge t0+k
  task automatic wait_at(input int k);
    while (cyc < t0 + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_frame(input logic [ND-1:0][6:0] segs, input logic [ND-1:0] dpm, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.dig = ND'(1 << i);
      e.seg = segs[i];
      e.dp  = dpm[i];
      exp_q.push_back(e);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [ND-1:0] d, input int k);
    wait_at(k);
    value   = v;
    dp_mask = d;
    load    = 1'b1;
    wait_at(k + 1);
    load    = 1'b0;
  endtask

  // monitor: one comparison set per newly lit digit
  always @(negedge clk) begin
    if (dig_en != '0 && dig_en != prev_dig) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_digit: got dig_en=%b seg=%h, required dark", dig_en, seg);
      end else begin
        mon_e = exp_q.pop_front();
        chk("slot_dig_en", 32'(dig_en), 32'(mon_e.dig));
        chk("slot_seg",    32'(seg),    32'(mon_e.seg));
        chk("slot_dp",     32'(dp),     32'(mon_e.dp));
        mon_inv_req = ~{seg, dp, dig_en};
        chk("invert_pins", 32'({inv_seg, inv_dp, inv_dig}), 32'(mon_inv_req));
      end
    end
    prev_dig = dig_en;
  end

`ifdef HEX_SCAN_LZB_EN
  localparam logic [ND-1:0][6:0] F_ZERO = {7'h00, 7'h00, 7'h00, 7'h3F};
  localparam logic [ND-1:0][6:0] F_0040 = {7'h00, 7'h00, 7'h66, 7'h3F};
`else
  localparam logic [ND-1:0][6:0] F_ZERO = {7'h3F, 7'h3F, 7'h3F, 7'h3F};
  localparam logic [ND-1:0][6:0] F_0040 = {7'h3F, 7'h3F, 7'h66, 7'h3F};
`endif

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; value = '0; dp_mask = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_dig_en", 32'(dig_en), 32'h0);
    chk("reset_seg",    32'(seg),    32'h0);
    chk("reset_upd",    32'(upd_pending), 32'h0);
    chk("reset_inv",    32'({inv_seg, inv_dp, inv_dig}), 32'hFFF);

    // frame 0: active=0; digit k lights at t0+2+6k, commits at t0+1+24f
    t0 = cyc;
    push_frame(F_ZERO, 4'b0000, 4);
    en = 1'b1;

    push_frame({7'h77, 7'h6D, 7'h71, 7'h3F}, 4'b0100, 4);   // A5F0
    do_load(16'hA5F0, 4'b0100, 10);
    chk("upd_after_load", 32'(upd_pending), 32'h1);
    wait_at(24);
    chk("upd_before_wrap", 32'(upd_pending), 32'h1);
    wait_at(25);
    chk("upd_after_wrap", 32'(upd_pending), 32'h0);

    // two loads in one frame: last wins
    push_frame({7'h5B, 7'h5B, 7'h5B, 7'h5B}, 4'b1001, 4);   // 2222
    do_load(16'h1111, 4'b0000, 30);
    do_load(16'h2222, 4'b1001, 40);

    // load on the commit edge (t0+73): 4444 commits, 3333 stays pending
    push_frame({7'h66, 7'h66, 7'h66, 7'h66}, 4'b0010, 4);   // 4444
    push_frame({7'h4F, 7'h4F, 7'h4F, 7'h4F}, 4'b0000, 3);   // 3333, digits 0..2
    do_load(16'h4444, 4'b0010, 55);
    do_load(16'h3333, 4'b0000, 72);
    chk("upd_load_on_commit", 32'(upd_pending), 32'h1);
    wait_at(96);
    chk("upd_held_to_next_wrap", 32'(upd_pending), 32'h1);
    wait_at(97);
    chk("upd_cleared_3333", 32'(upd_pending), 32'h0);

    // en drop during digit 2 (lit from t0+110), pending 5555
    do_load(16'h5555, 4'b1111, 100);
    push_frame({7'h6D, 7'h6D, 7'h6D, 7'h6D}, 4'b1111, 2);   // 5555, digits 0..1
    wait_at(110);
    en = 1'b0;
    wait_at(111);
    chk("dark_after_en_drop", 32'({seg, dig_en}), 32'h0);
    wait_at(115);
    en = 1'b1;
    wait_at(116);
    chk("dark_first_cycle_on", 32'(dig_en), 32'h0);
    chk("upd_commit_from_off", 32'(upd_pending), 32'h0);
    wait_at(117);
    chk("restart_digit0", 32'({seg, dig_en}), 32'({7'h6D, 4'b0001}));

    // reset mid-SHOW (digit 1 lit from t0+123) with a load pending
    do_load(16'h6666, 4'b0000, 119);
    wait_at(124);
    rst = 1'b1;
    en  = 1'b0;
    wait_at(125);
    chk("midrst_dig_en", 32'(dig_en), 32'h0);
    chk("midrst_seg_dp", 32'({seg, dp}), 32'h0);
    chk("midrst_upd",    32'(upd_pending), 32'h0);
    chk("midrst_inv",    32'({inv_seg, inv_dp, inv_dig}), 32'hFFF);
    rst = 1'b0;

    // leading-zero patterns: 0040 committed at enable, then 0000
    do_load(16'h0040, 4'b0000, 127);
    chk("upd_while_off", 32'(upd_pending), 32'h1);
    push_frame(F_0040, 4'b0000, 4);
    push_frame(F_ZERO, 4'b0000, 4);
    wait_at(130);
    en = 1'b1;
    do_load(16'h0000, 4'b0000, 140);
    wait_at(176);
    en = 1'b0;
    wait_at(177);
    chk("final_dark", 32'(dig_en), 32'h0);
    wait_at(185);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
